// File: rtl/prog_sender.sv
// Streams a program image to a UART transmitter: the "-p" preamble, the image
// bytes from memory in ascending address order, then a silent gap for the target.
module prog_sender #(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int IDLE_CYCLES  = 2 * SYS_CLK_FREQ,
  parameter int ADDR_W       = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] length_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_busy_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TX_DASH = 3'd1;
  localparam logic [2:0] S_TX_P    = 3'd2;
  localparam logic [2:0] S_RD      = 3'd3;
  localparam logic [2:0] S_TX_DATA = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;
  localparam logic [2:0] S_SILENT  = 3'd6;

  localparam logic [31:0] LAST_CNT = 32'(IDLE_CYCLES - 1);
  localparam logic [7:0]  BYTE_DASH = 8'h2D;
  localparam logic [7:0]  BYTE_P    = 8'h70;

  logic [2:0]        state_reg;
  logic [2:0]        ret_state_reg;
  logic              wait_first_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] len_reg;
  logic [31:0]       cnt_reg;
  logic              data_pending_reg;
  logic [7:0]        data_reg;
  logic [7:0]        tx_byte_reg;
  logic              tx_start_reg;
  logic              err_reg;

  // done_o is decoded from SILENT so busy_o is still high in the done cycle,
  // which makes a start arriving alongside done_o fall into the ignored case.
  assign rd_en_o    = (state_reg == S_RD);
  assign rd_addr_o  = addr_reg;
  assign tx_start_o = tx_start_reg;
  assign tx_byte_o  = tx_byte_reg;
  assign busy_o     = (state_reg != S_IDLE);
  assign done_o     = (state_reg == S_SILENT) && (cnt_reg == LAST_CNT);
  assign err_o      = err_reg;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg        <= S_IDLE;
      ret_state_reg    <= S_IDLE;
      wait_first_reg   <= 1'b0;
      addr_reg         <= '0;
      len_reg          <= '0;
      cnt_reg          <= '0;
      data_pending_reg <= 1'b0;
      data_reg         <= 8'h00;
      tx_byte_reg      <= 8'h00;
      tx_start_reg     <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            if (length_i != '0) begin
              len_reg   <= length_i;
              addr_reg  <= '0;
              state_reg <= S_TX_DASH;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        S_TX_DASH: begin
          if (!tx_busy_i) begin
            tx_start_reg   <= 1'b1;
            tx_byte_reg    <= BYTE_DASH;
            ret_state_reg  <= S_TX_P;
            wait_first_reg <= 1'b1;
            state_reg      <= S_WAIT_TX;
          end
        end
        S_TX_P: begin
          if (!tx_busy_i) begin
            tx_start_reg   <= 1'b1;
            tx_byte_reg    <= BYTE_P;
            ret_state_reg  <= S_RD;
            wait_first_reg <= 1'b1;
            state_reg      <= S_WAIT_TX;
          end
        end
        S_RD: begin
          data_pending_reg <= 1'b1;
          state_reg        <= S_TX_DATA;
        end
        S_TX_DATA: begin
          // The memory word is only valid in the first TX_DATA cycle; keep a copy
          // in case the transmitter is still busy and the launch is delayed.
          if (data_pending_reg) begin
            data_reg         <= rd_data_i;
            data_pending_reg <= 1'b0;
          end
          if (!tx_busy_i) begin
            tx_start_reg   <= 1'b1;
            tx_byte_reg    <= data_pending_reg ? rd_data_i : data_reg;
            addr_reg       <= addr_reg + ADDR_W'(1);
            ret_state_reg  <= S_TX_DATA;
            wait_first_reg <= 1'b1;
            state_reg      <= S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          if (wait_first_reg) begin
            wait_first_reg <= 1'b0;
          end else if (!tx_busy_i) begin
            if (ret_state_reg == S_TX_DATA) begin
              state_reg <= (addr_reg == len_reg) ? S_SILENT : S_RD;
            end else begin
              state_reg <= ret_state_reg;
            end
          end
        end
        S_SILENT: begin
          if (cnt_reg == LAST_CNT) begin
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sender.sv
// Directed and randomized checks of prog_sender against a byte-stream reference
// built from the image memory, with a simple busy-for-N-cycles transmitter model.
module tb_prog_sender;

  localparam int IDLE = 20;
  localparam int AW   = 8;

  logic          clk_i    = 1'b0;
  logic          reset_i  = 1'b0;
  logic          start_i  = 1'b0;
  logic [AW-1:0] length_i = '0;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [7:0]    rd_data_i = 8'h00;
  logic          tx_start_o;
  logic [7:0]    tx_byte_o;
  logic          tx_busy_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem [0:255];
  logic [7:0] rx_q [$];
  logic [7:0] last_byte = 8'h00;
  int  busy_cnt   = 0;
  int  busy_len   = 10;
  logic ext_busy  = 1'b0;
  int  cyc        = 0;
  int  fall_cyc   = 0;
  int  done_cyc   = 0;
  int  done_count = 0;
  int  err_count  = 0;

  assign tx_busy_i = ext_busy || (busy_cnt != 0);

  always #5 clk_i = ~clk_i;

  prog_sender #(
    .SYS_CLK_FREQ(1000),
    .IDLE_CYCLES (IDLE),
    .ADDR_W      (AW)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .length_i  (length_i),
    .rd_en_o   (rd_en_o),
    .rd_addr_o (rd_addr_o),
    .rd_data_i (rd_data_i),
    .tx_start_o(tx_start_o),
    .tx_byte_o (tx_byte_o),
    .tx_busy_i (tx_busy_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Image memory: one-cycle registered read.
  always @(posedge clk_i) begin
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
  end

  // Transmitter: busy for busy_len cycles after each load, logs every byte.
  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy_cnt <= 0;
    end else if (tx_start_o) begin
      check("tx_start_while_busy", {31'd0, tx_busy_i}, 32'd0);
      rx_q.push_back(tx_byte_o);
      last_byte <= tx_byte_o;
      busy_cnt  <= busy_len;
    end else if (busy_cnt != 0) begin
      if (busy_cnt == 1) begin
        check("tx_byte_stable", {24'd0, tx_byte_o}, {24'd0, last_byte});
        fall_cyc <= cyc;
      end
      busy_cnt <= busy_cnt - 1;
    end
  end

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (done_o) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
    end
    if (err_o) err_count <= err_count + 1;
  end

  task automatic send(input int len);
    @(negedge clk_i);
    start_i  = 1'b1;
    length_i = AW'(len);
    @(negedge clk_i);
    start_i  = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int n = 0;
    while (done_count == prev && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check("done_seen", done_count, prev + 1);
  endtask

  task automatic check_stream(input int len);
    check("stream_len", rx_q.size(), len + 2);
    if (rx_q.size() == len + 2) begin
      check("stream_dash", {24'd0, rx_q[0]}, 32'h2D);
      check("stream_p", {24'd0, rx_q[1]}, 32'h70);
      for (int i = 0; i < len; i++) begin
        check("stream_data", {24'd0, rx_q[i+2]}, {24'd0, mem[i]});
      end
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_seq(input int len, input int blen);
    int prev;
    busy_len = blen;
    rx_q.delete();
    prev = done_count;
    send(len);
    wait_done(prev, 30000);
    check_stream(len);
    // Silence is measured from the cycle the last busy drop becomes visible.
    check("done_gap", done_cyc - fall_cyc, IDLE + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_start"}, {31'd0, tx_start_o}, 32'd0);
    check({tag, "_rd_en"}, {31'd0, rd_en_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    check({tag, "_tx_byte"}, {24'd0, tx_byte_o}, 32'd0);
  endtask

  initial begin
    int prev;
    int errs;
    int n;

    fill_mem();
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    reset_i = 1'b1;
    repeat (5) @(negedge clk_i);
    check("post_reset_busy", {31'd0, busy_o}, 32'd0);
    check("post_reset_silent", rx_q.size(), 0);

    // Reference image from the requirements example.
    mem[0] = 8'hAA; mem[1] = 8'h55; mem[2] = 8'h13;
    run_seq(3, 10);
    check("no_err_normal", err_count, 0);

    // Zero length is rejected with a single err pulse.
    rx_q.delete();
    @(negedge clk_i);
    start_i  = 1'b1;
    length_i = '0;
    @(negedge clk_i);
    start_i  = 1'b0;
    check("zero_len_err", {31'd0, err_o}, 32'd1);
    check("zero_len_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    check("zero_len_err_pulse", {31'd0, err_o}, 32'd0);
    check("zero_len_err_count", err_count, 1);
    repeat (5) @(negedge clk_i);
    check("zero_len_no_tx", rx_q.size(), 0);
    check("zero_len_idle", {31'd0, busy_o}, 32'd0);

    // Starts while streaming, and one coinciding with done_o, are ignored.
    fill_mem();
    busy_len = 10;
    rx_q.delete();
    prev = done_count;
    errs = err_count;
    send(5);
    repeat (15) @(negedge clk_i);
    start_i  = 1'b1;
    length_i = AW'($urandom_range(1, 9));
    @(negedge clk_i);
    start_i  = 1'b0;
    repeat (23) @(negedge clk_i);
    start_i  = 1'b1;
    length_i = '0;
    @(negedge clk_i);
    start_i  = 1'b0;
    n = 0;
    while (!done_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("done_level_seen", {31'd0, done_o}, 32'd1);
    start_i  = 1'b1;
    length_i = AW'(7);
    @(negedge clk_i);
    start_i  = 1'b0;
    check("start_at_done_ignored", {31'd0, busy_o}, 32'd0);
    check("single_done", done_count, prev + 1);
    check_stream(5);
    repeat (30) @(negedge clk_i);
    check("no_second_sequence", rx_q.size(), 7);
    check("no_err_when_busy", err_count, errs);

    // Transmitter already busy: the preamble waits for it.
    fill_mem();
    busy_len = 10;
    rx_q.delete();
    prev = done_count;
    ext_busy = 1'b1;
    send(2);
    repeat (50) @(negedge clk_i);
    check("withheld_while_busy", rx_q.size(), 0);
    check("busy_while_withheld", {31'd0, busy_o}, 32'd1);
    ext_busy = 1'b0;
    wait_done(prev, 30000);
    check_stream(2);

    // Reset in the middle of the second data byte.
    fill_mem();
    busy_len = 10;
    rx_q.delete();
    send(4);
    n = 0;
    while (rx_q.size() < 4 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("reached_second_data", rx_q.size(), 4);
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk_i);
    reset_i = 1'b1;
    rx_q.delete();
    repeat (10) @(negedge clk_i);
    check("no_tx_after_reset", rx_q.size(), 0);
    run_seq(4, 10);

    // Randomized lengths and transmitter speeds.
    for (int k = 0; k < 4; k++) begin
      fill_mem();
      run_seq($urandom_range(1, 20), $urandom_range(1, 12));
    end

    // Full address range: every byte sent once, no wrap back to 0.
    fill_mem();
    run_seq((1 << AW) - 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
